// File: rtl/riscv_privileged_pkg.sv
// Machine-mode CSR types shared by the core-side CSR access path and the CSR file.
// Holds the command encoding, Zicsr op encoding and the access sequencer states.
package riscv_privileged_pkg;

    localparam int MXLEN = 64;

    typedef logic [11:0] csr_address_t;

    typedef enum logic [1:0] {
        NO_COMMAND = 2'b00,
        READ_ONLY  = 2'b01,
        WRITE_ONLY = 2'b10,
        READ_WRITE = 2'b11
    } csr_command_t;

    // funct3 encodings; 000 and 100 are not Zicsr ops.
    typedef enum logic [2:0] {
        CSR_OP_NONE0 = 3'b000,
        CSRRW        = 3'b001,
        CSRRS        = 3'b010,
        CSRRC        = 3'b011,
        CSR_OP_NONE4 = 3'b100,
        CSRRWI       = 3'b101,
        CSRRSI       = 3'b110,
        CSRRCI       = 3'b111
    } csr_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } csr_access_state_t;

    function automatic logic csr_op_is_legal(csr_op_t op);
        return op[1:0] != 2'b00;
    endfunction

    function automatic logic csr_op_is_swap(csr_op_t op);
        return op[1:0] == 2'b01;
    endfunction

    function automatic logic csr_op_is_immediate(csr_op_t op);
        return op[2];
    endfunction

    // Address bits [11:10] == 2'b11 mark the read-only CSR space.
    function automatic logic csr_address_is_readonly(csr_address_t address);
        return address[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational read-modify-write datapath: swap, set or clear the old CSR value with src.
module csr_rmw_alu #(
    parameter int MXLEN = riscv_privileged_pkg::MXLEN
) (
    input  riscv_privileged_pkg::csr_op_t op,
    input  logic [MXLEN-1:0]              old_value,
    input  logic [MXLEN-1:0]              src,
    output logic [MXLEN-1:0]              new_value
);
    import riscv_privileged_pkg::*;

    always_comb begin
        new_value = '0;
        unique case (op)
            CSRRW, CSRRWI: new_value = src;
            CSRRS, CSRRSI: new_value = old_value | src;
            CSRRC, CSRRCI: new_value = old_value & ~src;
            default:       new_value = '0;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Sequences one Zicsr instruction through read and write phases of the CSR file.
// Optional: define CSR_ACCESS_READONLY_CHECK_EN to reject writes to the read-only CSR space locally.
module csr_access_unit #(
    parameter int MXLEN = riscv_privileged_pkg::MXLEN
) (
    input  logic                               clock_i,
    input  logic                               reset_ni,
    input  logic                               req_valid_i,
    output logic                               req_ready_o,
    input  logic [2:0]                         req_funct3_i,
    input  riscv_privileged_pkg::csr_address_t req_csr_address_i,
    input  logic [4:0]                         req_rs1_index_i,
    input  logic [MXLEN-1:0]                   req_rs1_data_i,
    input  logic [4:0]                         req_rd_index_i,
    output riscv_privileged_pkg::csr_address_t csr_address_o,
    output riscv_privileged_pkg::csr_command_t csr_command_o,
    output logic [MXLEN-1:0]                   csr_write_data_o,
    input  logic [MXLEN-1:0]                   csr_read_data_i,
    input  logic                               csr_read_data_valid_i,
    output logic                               resp_valid_o,
    input  logic                               resp_ready_i,
    output logic [MXLEN-1:0]                   resp_data_o,
    output logic [4:0]                         resp_rd_index_o,
    output logic                               resp_write_rd_o,
    output logic                               resp_illegal_o
);
    import riscv_privileged_pkg::*;

    csr_access_state_t state, state_next;

    csr_op_t          op_q;
    csr_address_t     address_q;
    logic [4:0]       rs1_index_q;
    logic [MXLEN-1:0] rs1_data_q;
    logic [4:0]       rd_index_q;
    logic [MXLEN-1:0] old_value_q;
    logic             illegal_q;

    csr_op_t          req_op;
    logic [MXLEN-1:0] src;
    logic [MXLEN-1:0] new_value;
    logic             read_needed;
    logic             write_needed;
    logic             readonly_violation;
    logic             read_illegal;

    assign req_op = csr_op_t'(req_funct3_i);

    assign src = csr_op_is_immediate(op_q) ? {{(MXLEN-5){1'b0}}, rs1_index_q} : rs1_data_q;

    // Swaps skip the read when rd is x0; set/clear skip the write when rs1/zimm is zero.
    assign read_needed  = csr_op_is_swap(op_q) ? (rd_index_q != 5'd0) : 1'b1;
    assign write_needed = csr_op_is_swap(op_q) ? 1'b1 : (rs1_index_q != 5'd0);

`ifdef CSR_ACCESS_READONLY_CHECK_EN
    assign readonly_violation = write_needed && csr_address_is_readonly(address_q);
`else
    assign readonly_violation = 1'b0;
`endif

    assign read_illegal = !csr_read_data_valid_i || readonly_violation;

    csr_rmw_alu #(
        .MXLEN(MXLEN)
    ) u_rmw_alu (
        .op       (op_q),
        .old_value(old_value_q),
        .src      (src),
        .new_value(new_value)
    );

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request fields are captured on accept; the old value and legality are captured in READ.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            op_q        <= CSR_OP_NONE0;
            address_q   <= '0;
            rs1_index_q <= '0;
            rs1_data_q  <= '0;
            rd_index_q  <= '0;
            old_value_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        op_q        <= req_op;
                        address_q   <= req_csr_address_i;
                        rs1_index_q <= req_rs1_index_i;
                        rs1_data_q  <= req_rs1_data_i;
                        rd_index_q  <= req_rd_index_i;
                        old_value_q <= '0;
                        illegal_q   <= !csr_op_is_legal(req_op);
                    end
                end
                READ: begin
                    old_value_q <= csr_read_data_i;
                    illegal_q   <= read_illegal;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (req_valid_i) begin
                    state_next = csr_op_is_legal(req_op) ? READ : RESP;
                end
            end
            READ: begin
                state_next = (read_illegal || !write_needed) ? RESP : WRITE;
            end
            WRITE: state_next = RESP;
            RESP: begin
                if (resp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // CSR file side is only driven in READ/WRITE; response side only in RESP.
    always_comb begin
        req_ready_o      = 1'b0;
        csr_address_o    = '0;
        csr_command_o    = NO_COMMAND;
        csr_write_data_o = '0;
        resp_valid_o     = 1'b0;
        resp_data_o      = '0;
        resp_rd_index_o  = '0;
        resp_write_rd_o  = 1'b0;
        resp_illegal_o   = 1'b0;
        unique case (state)
            IDLE: req_ready_o = 1'b1;
            READ: begin
                csr_address_o = address_q;
                csr_command_o = read_needed ? READ_ONLY : NO_COMMAND;
            end
            WRITE: begin
                csr_address_o    = address_q;
                csr_command_o    = WRITE_ONLY;
                csr_write_data_o = new_value;
            end
            RESP: begin
                resp_valid_o    = 1'b1;
                resp_data_o     = illegal_q ? '0 : old_value_q;
                resp_rd_index_o = rd_index_q;
                resp_write_rd_o = !illegal_q && (rd_index_q != 5'd0);
                resp_illegal_o  = illegal_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed, table-driven bench for csr_access_unit plus reset-during-write and stall sequences.
module tb_csr_access_unit;
    import riscv_privileged_pkg::*;

    logic               clock_i = 1'b0;
    logic               reset_ni;
    logic               req_valid_i;
    logic               req_ready_o;
    logic [2:0]         req_funct3_i;
    csr_address_t       req_csr_address_i;
    logic [4:0]         req_rs1_index_i;
    logic [MXLEN-1:0]   req_rs1_data_i;
    logic [4:0]         req_rd_index_i;
    csr_address_t       csr_address_o;
    csr_command_t       csr_command_o;
    logic [MXLEN-1:0]   csr_write_data_o;
    logic [MXLEN-1:0]   csr_read_data_i;
    logic               csr_read_data_valid_i;
    logic               resp_valid_o;
    logic               resp_ready_i;
    logic [MXLEN-1:0]   resp_data_o;
    logic [4:0]         resp_rd_index_o;
    logic               resp_write_rd_o;
    logic               resp_illegal_o;

    int checks = 0;
    int errors = 0;

    csr_access_unit #(.MXLEN(MXLEN)) dut (
        .clock_i              (clock_i),
        .reset_ni             (reset_ni),
        .req_valid_i          (req_valid_i),
        .req_ready_o          (req_ready_o),
        .req_funct3_i         (req_funct3_i),
        .req_csr_address_i    (req_csr_address_i),
        .req_rs1_index_i      (req_rs1_index_i),
        .req_rs1_data_i       (req_rs1_data_i),
        .req_rd_index_i       (req_rd_index_i),
        .csr_address_o        (csr_address_o),
        .csr_command_o        (csr_command_o),
        .csr_write_data_o     (csr_write_data_o),
        .csr_read_data_i      (csr_read_data_i),
        .csr_read_data_valid_i(csr_read_data_valid_i),
        .resp_valid_o         (resp_valid_o),
        .resp_ready_i         (resp_ready_i),
        .resp_data_o          (resp_data_o),
        .resp_rd_index_o      (resp_rd_index_o),
        .resp_write_rd_o      (resp_write_rd_o),
        .resp_illegal_o       (resp_illegal_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [2:0]  funct3;
        logic [11:0] address;
        logic [4:0]  rs1_index;
        logic [63:0] rs1_data;
        logic [4:0]  rd;
        logic [63:0] old_value;
        logic        valid;
        logic        exp_read;
        logic        exp_write;
        logic [63:0] exp_wdata;
        int          exp_cycle;
        logic [63:0] exp_data;
        logic        exp_write_rd;
        logic        exp_illegal;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveRequest(input logic [2:0] funct3, input logic [11:0] address, input logic [4:0] rs1_index,
                                input logic [63:0] rs1_data, input logic [4:0] rd, input logic [63:0] old_value,
                                input logic valid);
        req_valid_i           = 1'b1;
        req_funct3_i          = funct3;
        req_csr_address_i     = address;
        req_rs1_index_i       = rs1_index;
        req_rs1_data_i        = rs1_data;
        req_rd_index_i        = rd;
        csr_read_data_i       = old_value;
        csr_read_data_valid_i = valid;
    endtask

    // One transaction: accept at cycle 0, then watch the CSR side until the response appears.
    task automatic applyStimulus(input vec_t v, input int idx);
        logic        got;
        logic        wrote;
        logic [63:0] wdata;
        int          cycle;
        got = 1'b0; wrote = 1'b0; wdata = '0; cycle = 0;
        @(negedge clock_i);
        resp_ready_i = 1'b1;
        driveRequest(v.funct3, v.address, v.rs1_index, v.rs1_data, v.rd, v.old_value, v.valid);
        checkOutput($sformatf("v%0d_req_ready", idx), req_ready_o, 1);
        @(posedge clock_i);
        #1 req_valid_i = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clock_i);
            if (c == 1) begin
                checkOutput($sformatf("v%0d_c1_command", idx), csr_command_o, v.exp_read ? READ_ONLY : NO_COMMAND);
                if (v.exp_cycle > 1) begin
                    checkOutput($sformatf("v%0d_c1_address", idx), csr_address_o, v.address);
                end
            end
            if (csr_command_o == WRITE_ONLY) begin
                wrote = 1'b1;
                wdata = csr_write_data_o;
            end
            if (resp_valid_o) begin
                got = 1'b1;
                cycle = c;
            end
        end
        checkOutput($sformatf("v%0d_resp_seen", idx), got, 1);
        checkOutput($sformatf("v%0d_resp_cycle", idx), cycle, v.exp_cycle);
        checkOutput($sformatf("v%0d_wrote", idx), wrote, v.exp_write);
        checkOutput($sformatf("v%0d_wdata", idx), wdata, v.exp_write ? v.exp_wdata : 64'h0);
        checkOutput($sformatf("v%0d_resp_data", idx), resp_data_o, v.exp_data);
        checkOutput($sformatf("v%0d_write_rd", idx), resp_write_rd_o, v.exp_write_rd);
        checkOutput($sformatf("v%0d_illegal", idx), resp_illegal_o, v.exp_illegal);
        checkOutput($sformatf("v%0d_rd_index", idx), resp_rd_index_o, v.rd);
        @(negedge clock_i);
        checkOutput($sformatf("v%0d_back_idle", idx), {req_ready_o, resp_valid_o}, 2'b10);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic got;
        vecs[0]  = '{3'b001, 12'h340, 5'd1,  64'h1234, 5'd5, 64'h0,  1'b1, 1'b1, 1'b1, 64'h1234, 3, 64'h0, 1'b1, 1'b0};
        vecs[1]  = '{3'b010, 12'h304, 5'd2,  64'h888,  5'd6, 64'h8,  1'b1, 1'b1, 1'b1, 64'h888,  3, 64'h8, 1'b1, 1'b0};
        vecs[2]  = '{3'b011, 12'h304, 5'd0,  64'hFF,   5'd3, 64'h8,  1'b1, 1'b1, 1'b0, 64'h0,    2, 64'h8, 1'b1, 1'b0};
        vecs[3]  = '{3'b101, 12'h7C0, 5'd7,  64'h0,    5'd4, 64'h55, 1'b0, 1'b1, 1'b0, 64'h0,    2, 64'h0, 1'b0, 1'b1};
`ifdef CSR_ACCESS_READONLY_CHECK_EN
        vecs[4]  = '{3'b001, 12'hF11, 5'd1,  64'hAA,   5'd2, 64'h42, 1'b1, 1'b1, 1'b0, 64'h0,    2, 64'h0, 1'b0, 1'b1};
`else
        vecs[4]  = '{3'b001, 12'hF11, 5'd1,  64'hAA,   5'd2, 64'h42, 1'b1, 1'b1, 1'b1, 64'hAA,   3, 64'h42, 1'b1, 1'b0};
`endif
        vecs[5]  = '{3'b000, 12'h340, 5'd1,  64'h11,   5'd5, 64'h77, 1'b1, 1'b0, 1'b0, 64'h0,    1, 64'h0, 1'b0, 1'b1};
        vecs[6]  = '{3'b100, 12'h340, 5'd1,  64'h11,   5'd9, 64'h77, 1'b1, 1'b0, 1'b0, 64'h0,    1, 64'h0, 1'b0, 1'b1};
        vecs[7]  = '{3'b101, 12'h340, 5'd31, 64'h0,    5'd0, 64'h0,  1'b1, 1'b0, 1'b1, 64'h1F,   3, 64'h0, 1'b0, 1'b0};
        vecs[8]  = '{3'b110, 12'h300, 5'd3,  64'h0,    5'd1, 64'hC0, 1'b1, 1'b1, 1'b1, 64'hC3,   3, 64'hC0, 1'b1, 1'b0};
        vecs[9]  = '{3'b111, 12'h300, 5'd4,  64'h0,    5'd9, 64'hFF, 1'b1, 1'b1, 1'b1, 64'hFB,   3, 64'hFF, 1'b1, 1'b0};
        vecs[10] = '{3'b011, 12'h341, 5'd5,  64'hF0F0, 5'd10, 64'hFFFF, 1'b1, 1'b1, 1'b1, 64'h0F0F, 3, 64'hFFFF, 1'b1, 1'b0};
        vecs[11] = '{3'b010, 12'h342, 5'd6,  64'h8000_0000_0000_0000, 5'd11, 64'h1, 1'b1, 1'b1, 1'b1,
                     64'h8000_0000_0000_0001, 3, 64'h1, 1'b1, 1'b0};

        reset_ni = 1'b0;
        req_valid_i = 1'b0; req_funct3_i = '0; req_csr_address_i = '0; req_rs1_index_i = '0;
        req_rs1_data_i = '0; req_rd_index_i = '0; csr_read_data_i = '0; csr_read_data_valid_i = 1'b0;
        resp_ready_i = 1'b1;
        #1;
        checkOutput("reset_req_ready", req_ready_o, 1);
        checkOutput("reset_resp_valid", resp_valid_o, 0);
        checkOutput("reset_command", csr_command_o, NO_COMMAND);
        checkOutput("reset_address", csr_address_o, 0);
        checkOutput("reset_wdata", csr_write_data_o, 0);
        checkOutput("reset_resp_fields", {resp_data_o, resp_rd_index_o, resp_write_rd_o, resp_illegal_o}, 0);
        repeat (2) @(negedge clock_i);
        reset_ni = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Reset pulse while in WRITE: command drops at once and no response follows.
        @(negedge clock_i);
        driveRequest(3'b001, 12'h340, 5'd1, 64'hDEAD, 5'd7, 64'h0, 1'b1);
        @(posedge clock_i);
        #1 req_valid_i = 1'b0;
        repeat (2) @(negedge clock_i);
        checkOutput("rst_pre_command", csr_command_o, WRITE_ONLY);
        reset_ni = 1'b0;
        #1;
        checkOutput("rst_command", csr_command_o, NO_COMMAND);
        checkOutput("rst_idle", {req_ready_o, resp_valid_o}, 2'b10);
        checkOutput("rst_address", csr_address_o, 0);
        #1 reset_ni = 1'b1;
        resp_ready_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock_i);
            checkOutput($sformatf("rst_quiet%0d", c), {resp_valid_o, req_ready_o, csr_command_o}, {1'b0, 1'b1, NO_COMMAND});
        end

        // Stalled response: held stable with no new accept, even with a request waiting.
        @(negedge clock_i);
        driveRequest(3'b010, 12'h304, 5'd2, 64'h30, 5'd8, 64'h5, 1'b1);
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clock_i);
            got = resp_valid_o;
        end
        checkOutput("stall_resp_seen", got, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock_i);
            checkOutput($sformatf("stall_hold%0d", c),
                        {resp_valid_o, req_ready_o, csr_command_o, resp_write_rd_o, resp_illegal_o},
                        {1'b1, 1'b0, NO_COMMAND, 1'b1, 1'b0});
            checkOutput($sformatf("stall_data%0d", c), resp_data_o, 64'h5);
        end
        resp_ready_i = 1'b1;
        @(posedge clock_i);
        #1 req_valid_i = 1'b0;
        @(negedge clock_i);
        checkOutput("stall_release_idle", {req_ready_o, resp_valid_o, csr_command_o}, {1'b1, 1'b0, NO_COMMAND});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
